// File: rtl/fifo_ram_multiport_pkg.sv
// Shared width helpers for the multiport register FIFO.
// ptr_width: bits needed to address every entry.
// ctr_width: pointer bits plus one wrap bit, used for head/tail tags.
package fifo_ram_multiport_pkg;

  function automatic int ptr_width(input int n_entries);
    return (n_entries > 1) ? $clog2(n_entries) : 1;
  endfunction

  function automatic int ctr_width(input int n_entries);
    return ptr_width(n_entries) + 1;
  endfunction

endpackage

// File: rtl/fifo_ram_multiport_chk.sv
// Checker for fifo_ram_multiport: a rollback tag must not lie beyond the
// current tail, measured from the head value after this cycle's dequeues.
// Ports: clk, rst, flush, rollback_en, rollback_tag, head (deq_addr lane 0),
//        tail (enq_addr lane 0), deq_valid, deq_ready.
module fifo_ram_multiport_chk
  import fifo_ram_multiport_pkg::*;
#(
  parameter int N_ENTRIES = 16,
  parameter int N_DEQ     = 2,
  localparam int CTR_WIDTH = ctr_width(N_ENTRIES)
) (
  input logic                 clk,
  input logic                 rst,
  input logic                 flush,
  input logic                 rollback_en,
  input logic [CTR_WIDTH-1:0] rollback_tag,
  input logic [CTR_WIDTH-1:0] head,
  input logic [CTR_WIDTH-1:0] tail,
  input logic [N_DEQ-1:0]     deq_valid,
  input logic [N_DEQ-1:0]     deq_ready
);

  logic [CTR_WIDTH-1:0] head_next_s, tag_ofs_s, tail_ofs_s;

  // Rebuild head_next from the prefix dequeue handshake.
  always_comb begin : head_next_blk
    logic run_s;
    run_s       = 1'b1;
    head_next_s = head;
    for (int i = 0; i < N_DEQ; i++) begin
      run_s       = run_s & deq_valid[i] & deq_ready[i];
      head_next_s = head_next_s + CTR_WIDTH'(run_s);
    end
    tag_ofs_s  = rollback_tag - head_next_s;
    tail_ofs_s = tail - head_next_s;
  end

  rollback_tag_in_range: assert property (
    @(posedge clk) disable iff (rst)
    (rollback_en && !flush) |-> (tag_ofs_s <= tail_ofs_s)
  );

endmodule

// File: rtl/fifo_ram_multiport_lane_prefix_ctr.sv
// Prefix-AND lane mask and leading-ones count.
// Ports:
//   req_vec   in  N               per-lane request (already qualified by readiness)
//   fire_mask out N               lane i set iff req_vec[0..i] are all 1
//   fire_cnt  out $clog2(N+1)     number of firing lanes
module lane_prefix_ctr #(
  parameter int N = 2
) (
  input  logic [N-1:0]           req_vec,
  output logic [N-1:0]           fire_mask,
  output logic [$clog2(N+1)-1:0] fire_cnt
);

  localparam int CW = $clog2(N + 1);

  // Walk the lanes once; a single zero kills every lane above it.
  always_comb begin : prefix_blk
    logic run_s;
    run_s     = 1'b1;
    fire_mask = '0;
    fire_cnt  = '0;
    for (int i = 0; i < N; i++) begin
      run_s        = run_s & req_vec[i];
      fire_mask[i] = run_s;
      fire_cnt     = fire_cnt + CW'(run_s);
    end
  end

endmodule

// File: rtl/fifo_ram_multiport.sv
// Circular register FIFO with N_ENQ enqueue lanes, N_DEQ dequeue lanes,
// random read/write ports, flush and tail rollback.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   enq_valid/enq_data       per-lane enqueue request and data (lane 0 in LSBs)
//   enq_ready/enq_addr       lane i ready iff free >= i+1; tag of tail+i
//   deq_ready                per-lane dequeue accept
//   deq_valid/deq_data/deq_addr  lane i valid iff count >= i+1; entry and tag at head+i
//   rd_addr/rd_data          combinational random read
//   wr_en/wr_addr/wr_data    random write, highest port wins, enqueue beats write
//   flush                    tail <= head, all lanes suppressed
//   rollback_en/rollback_tag tail <= rollback_tag, enqueues suppressed
//   count/full/empty         occupancy status
module fifo_ram_multiport
  import fifo_ram_multiport_pkg::*;
#(
  parameter int ENTRY_WIDTH   = 32,
  parameter int N_ENTRIES     = 16,
  parameter int N_ENQ         = 2,
  parameter int N_DEQ         = 2,
  parameter int N_READ_PORTS  = 2,
  parameter int N_WRITE_PORTS = 2,
  localparam int PTR_WIDTH    = ptr_width(N_ENTRIES),
  localparam int CTR_WIDTH    = ctr_width(N_ENTRIES)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [N_ENQ-1:0]                    enq_valid,
  input  logic [N_ENQ*ENTRY_WIDTH-1:0]        enq_data,
  output logic [N_ENQ-1:0]                    enq_ready,
  output logic [N_ENQ*CTR_WIDTH-1:0]          enq_addr,
  input  logic [N_DEQ-1:0]                    deq_ready,
  output logic [N_DEQ-1:0]                    deq_valid,
  output logic [N_DEQ*ENTRY_WIDTH-1:0]        deq_data,
  output logic [N_DEQ*CTR_WIDTH-1:0]          deq_addr,
  input  logic [N_READ_PORTS*PTR_WIDTH-1:0]   rd_addr,
  output logic [N_READ_PORTS*ENTRY_WIDTH-1:0] rd_data,
  input  logic [N_WRITE_PORTS-1:0]            wr_en,
  input  logic [N_WRITE_PORTS*PTR_WIDTH-1:0]  wr_addr,
  input  logic [N_WRITE_PORTS*ENTRY_WIDTH-1:0] wr_data,
  input  logic                                flush,
  input  logic                                rollback_en,
  input  logic [CTR_WIDTH-1:0]                rollback_tag,
  output logic [CTR_WIDTH-1:0]                count,
  output logic                                full,
  output logic                                empty
);

  typedef logic [PTR_WIDTH-1:0] ptr_t;
  typedef logic [CTR_WIDTH-1:0] ctr_t;

  localparam int ENQ_CW = $clog2(N_ENQ + 1);
  localparam int DEQ_CW = $clog2(N_DEQ + 1);

  ctr_t                   head_r, tail_r, count_s, free_s;
  logic [ENTRY_WIDTH-1:0] mem_r    [N_ENTRIES];
  logic [ENTRY_WIDTH-1:0] mem_wd_s [N_ENTRIES];
  logic [N_ENTRIES-1:0]   mem_we_s;
  logic [N_ENQ-1:0]       enq_req_s, enq_fire_s;
  logic [N_DEQ-1:0]       deq_req_s, deq_fire_s;
  logic [ENQ_CW-1:0]      n_enq_s;
  logic [DEQ_CW-1:0]      n_deq_s;

  // Wrap bit makes tail-head exact over the full 0..N_ENTRIES range.
  assign count_s = tail_r - head_r;
  assign free_s  = ctr_t'(N_ENTRIES) - count_s;
  assign count   = count_s;
  assign full    = (count_s == ctr_t'(N_ENTRIES));
  assign empty   = (count_s == ctr_t'(0));

  // Flush kills both directions, rollback only kills enqueues.
  assign enq_req_s = (flush || rollback_en) ? '0 : (enq_valid & enq_ready);
  assign deq_req_s = flush ? '0 : (deq_ready & deq_valid);

  lane_prefix_ctr #(.N(N_ENQ)) u_enq_prefix (
    .req_vec   (enq_req_s),
    .fire_mask (enq_fire_s),
    .fire_cnt  (n_enq_s)
  );

  lane_prefix_ctr #(.N(N_DEQ)) u_deq_prefix (
    .req_vec   (deq_req_s),
    .fire_mask (deq_fire_s),
    .fire_cnt  (n_deq_s)
  );

  // Lane status, tags and dequeue data from current head/tail only (no bypass).
  always_comb begin : lane_out_blk
    ctr_t tag_s;
    tag_s = '0;
    for (int i = 0; i < N_ENQ; i++) begin
      tag_s                              = tail_r + ctr_t'(i);
      enq_ready[i]                       = (free_s >= ctr_t'(i + 1));
      enq_addr[i*CTR_WIDTH +: CTR_WIDTH] = tag_s;
    end
    for (int i = 0; i < N_DEQ; i++) begin
      tag_s                                  = head_r + ctr_t'(i);
      deq_valid[i]                           = (count_s >= ctr_t'(i + 1));
      deq_addr[i*CTR_WIDTH +: CTR_WIDTH]     = tag_s;
      deq_data[i*ENTRY_WIDTH +: ENTRY_WIDTH] = mem_r[tag_s[PTR_WIDTH-1:0]];
    end
  end

  // Random read ports see registered contents only.
  always_comb begin
    for (int r = 0; r < N_READ_PORTS; r++) begin
      rd_data[r*ENTRY_WIDTH +: ENTRY_WIDTH] = mem_r[rd_addr[r*PTR_WIDTH +: PTR_WIDTH]];
    end
  end

  // Per-entry write select: later assignments win, so write ports are scanned
  // low to high and enqueue lanes last to override any random write.
  always_comb begin : mem_wr_blk
    logic hit_s;
    ctr_t etag_s;
    hit_s  = 1'b0;
    etag_s = '0;
    for (int e = 0; e < N_ENTRIES; e++) begin
      mem_we_s[e] = 1'b0;
      mem_wd_s[e] = mem_r[e];
      for (int p = 0; p < N_WRITE_PORTS; p++) begin
        hit_s        = wr_en[p] && (wr_addr[p*PTR_WIDTH +: PTR_WIDTH] == ptr_t'(e));
        mem_we_s[e]  = mem_we_s[e] | hit_s;
        mem_wd_s[e]  = hit_s ? wr_data[p*ENTRY_WIDTH +: ENTRY_WIDTH] : mem_wd_s[e];
      end
      for (int i = 0; i < N_ENQ; i++) begin
        etag_s       = tail_r + ctr_t'(i);
        hit_s        = enq_fire_s[i] && (etag_s[PTR_WIDTH-1:0] == ptr_t'(e));
        mem_we_s[e]  = mem_we_s[e] | hit_s;
        mem_wd_s[e]  = hit_s ? enq_data[i*ENTRY_WIDTH +: ENTRY_WIDTH] : mem_wd_s[e];
      end
    end
  end

  // Head/tail pointer update and entry storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_r <= '0;
      tail_r <= '0;
      for (int e = 0; e < N_ENTRIES; e++) begin
        mem_r[e] <= '0;
      end
    end else begin
      // n_deq is already zero during flush, so head holds there.
      head_r <= head_r + ctr_t'(n_deq_s);
      if (flush) begin
        tail_r <= head_r;
      end else if (rollback_en) begin
        tail_r <= rollback_tag;
      end else begin
        tail_r <= tail_r + ctr_t'(n_enq_s);
      end
      for (int e = 0; e < N_ENTRIES; e++) begin
        if (mem_we_s[e]) begin
          mem_r[e] <= mem_wd_s[e];
        end
      end
    end
  end

endmodule

// File: tb/tb_fifo_ram_multiport.sv
// Directed bench for fifo_ram_multiport (8 entries, 2 enq / 2 deq lanes).
// Driver pushes hand-computed {data, tag} on enqueue; a negedge monitor pops
// and compares whenever a dequeue lane fires.
module tb_fifo_ram_multiport;

  logic        clk;
  logic        rst;
  logic [1:0]  enq_valid;
  logic [63:0] enq_data;
  logic [1:0]  enq_ready;
  logic [7:0]  enq_addr;
  logic [1:0]  deq_ready;
  logic [1:0]  deq_valid;
  logic [63:0] deq_data;
  logic [7:0]  deq_addr;
  logic [5:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  wr_en;
  logic [5:0]  wr_addr;
  logic [63:0] wr_data;
  logic        flush;
  logic        rollback_en;
  logic [3:0]  rollback_tag;
  logic [3:0]  count;
  logic        full;
  logic        empty;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  fifo_ram_multiport #(
    .ENTRY_WIDTH(32), .N_ENTRIES(8), .N_ENQ(2), .N_DEQ(2),
    .N_READ_PORTS(2), .N_WRITE_PORTS(2)
  ) dut (
    .clk(clk), .rst(rst),
    .enq_valid(enq_valid), .enq_data(enq_data), .enq_ready(enq_ready), .enq_addr(enq_addr),
    .deq_ready(deq_ready), .deq_valid(deq_valid), .deq_data(deq_data), .deq_addr(deq_addr),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .flush(flush), .rollback_en(rollback_en), .rollback_tag(rollback_tag),
    .count(count), .full(full), .empty(empty)
  );

  fifo_ram_multiport_chk #(.N_ENTRIES(8), .N_DEQ(2)) u_chk (
    .clk(clk), .rst(rst), .flush(flush), .rollback_en(rollback_en),
    .rollback_tag(rollback_tag), .head(deq_addr[3:0]), .tail(enq_addr[3:0]),
    .deq_valid(deq_valid), .deq_ready(deq_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] d, input logic [3:0] t);
    exp_t e;
    e.data = d;
    e.tag  = t;
    exp_q.push_back(e);
  endtask

  task automatic idle();
    enq_valid = 2'b00; enq_data = 64'h0; deq_ready = 2'b00; rd_addr = 6'h0;
    wr_en = 2'b00; wr_addr = 6'h0; wr_data = 64'h0;
    flush = 1'b0; rollback_en = 1'b0; rollback_tag = 4'h0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pop one expected entry per firing dequeue lane.
  always @(negedge clk) begin : mon_blk
    logic run_s;
    exp_t e;
    if (!rst && !flush) begin
      run_s = 1'b1;
      for (int i = 0; i < 2; i++) begin
        run_s = run_s & deq_ready[i] & deq_valid[i];
        if (run_s) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL deq_unexpected: lane %0d data %0h with no entry expected", i, deq_data[i*32 +: 32]);
          end else begin
            e = exp_q.pop_front();
            chk("deq_data", {32'h0, deq_data[i*32 +: 32]}, {32'h0, e.data});
            chk("deq_tag", {60'h0, deq_addr[i*4 +: 4]}, {60'h0, e.tag});
          end
        end
      end
    end
  end

  initial begin : drv_blk
    exp_t e;
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // reset state
    @(negedge clk);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_enq_ready", 64'(enq_ready), 64'h3);
    chk("rst_deq_valid", 64'(deq_valid), 64'h0);
    chk("rst_enq_addr", 64'(enq_addr), 64'h10);
    chk("rst_deq_data", deq_data, 64'h0);
    cyc();

    // fill six entries two at a time
    for (int k = 0; k < 3; k++) begin
      enq_valid = 2'b11;
      enq_data  = {32'hA1 + 32'(2*k), 32'hA0 + 32'(2*k)};
      push(32'hA0 + 32'(2*k), 4'(2*k));
      push(32'hA1 + 32'(2*k), 4'(2*k + 1));
      @(negedge clk);
      chk("fill_count", 64'(count), 64'(2*k));
      chk("fill_enq_ready", 64'(enq_ready), 64'h3);
      cyc();
    end
    enq_valid = 2'b01; enq_data = {32'hDEAD, 32'hA6};
    push(32'hA6, 4'd6);
    @(negedge clk);
    chk("fill6_count", 64'(count), 64'd6);
    cyc();
    // one free slot: only lane 0 may fire
    enq_valid = 2'b11; enq_data = {32'hA8, 32'hA7};
    push(32'hA7, 4'd7);
    @(negedge clk);
    chk("c7_count", 64'(count), 64'd7);
    chk("c7_enq_ready", 64'(enq_ready), 64'h1);
    cyc();

    // full; deq_ready with a gap at lane 0 dequeues nothing
    idle(); deq_ready = 2'b10;
    @(negedge clk);
    chk("full_count", 64'(count), 64'd8);
    chk("full_flag", 64'(full), 64'd1);
    chk("full_enq_ready", 64'(enq_ready), 64'h0);
    chk("full_deq_valid", 64'(deq_valid), 64'h3);
    cyc();
    deq_ready = 2'b11;
    @(negedge clk);
    chk("gap_deq_count", 64'(count), 64'd8);
    chk("gap_deq_head", 64'(deq_addr), 64'h10);
    cyc();
    // enqueue with a gap at lane 0 is ignored
    enq_valid = 2'b10; enq_data = {32'hB9, 32'hB8};
    @(negedge clk);
    chk("d1_count", 64'(count), 64'd6);
    chk("d1_enq_ready", 64'(enq_ready), 64'h3);
    cyc();
    enq_valid = 2'b01; enq_data = {32'h0, 32'hB0};
    push(32'hB0, 4'd8);
    @(negedge clk);
    chk("gap_enq_count", 64'(count), 64'd4);
    cyc();

    // wrap: head=6, count=3, enq and deq two each
    enq_valid = 2'b11; enq_data = {32'hC1, 32'hC0};
    push(32'hC0, 4'd9);
    push(32'hC1, 4'd10);
    @(negedge clk);
    chk("wrap_count", 64'(count), 64'd3);
    chk("wrap_deq_addr", 64'(deq_addr), 64'h76);
    cyc();

    // two writes to entry 2, highest port wins, visible next cycle
    idle();
    wr_en = 2'b11; wr_addr = {3'd2, 3'd2}; wr_data = {32'h22, 32'h11};
    rd_addr = {3'd1, 3'd2};
    @(negedge clk);
    chk("post_wrap_count", 64'(count), 64'd3);
    chk("post_wrap_head", 64'(deq_addr), 64'h98);
    chk("post_wrap_tail", 64'(enq_addr), 64'hCB);
    chk("wr_old_rd", rd_data, {32'hC0, 32'hC1});
    e = exp_q[2]; e.data = 32'h22; exp_q[2] = e;
    cyc();

    // writes to entry 3 lose to a same-cycle enqueue there
    wr_en = 2'b11; wr_addr = {3'd3, 3'd3}; wr_data = {32'h44, 32'h33};
    enq_valid = 2'b01; enq_data = {32'h0, 32'hD0};
    rd_addr = {3'd3, 3'd2};
    push(32'hD0, 4'd11);
    @(negedge clk);
    chk("wr_new_rd", rd_data, {32'hA3, 32'h22});
    cyc();
    idle(); rd_addr = {3'd3, 3'd2}; deq_ready = 2'b01;
    @(negedge clk);
    chk("enq_beats_wr", rd_data, {32'hD0, 32'h22});
    chk("pre_rb_count", 64'(count), 64'd4);
    cyc();

    // rollback to tag 11 while dequeuing one; enqueue suppressed
    idle(); rollback_en = 1'b1; rollback_tag = 4'hB; deq_ready = 2'b01;
    enq_valid = 2'b01; enq_data = {32'h0, 32'hE0};
    @(negedge clk);
    chk("rb_count_before", 64'(count), 64'd3);
    chk("rb_tail_before", 64'(enq_addr), 64'hDC);
    void'(exp_q.pop_back());
    cyc();

    // flush with all lanes requesting
    idle(); flush = 1'b1; deq_ready = 2'b11;
    enq_valid = 2'b11; enq_data = {32'hF9, 32'hF8};
    @(negedge clk);
    chk("rb_count", 64'(count), 64'd1);
    chk("rb_enq_addr", 64'(enq_addr), 64'hCB);
    chk("rb_deq_addr", 64'(deq_addr), 64'hBA);
    chk("rb_deq_valid", 64'(deq_valid), 64'h1);
    exp_q.delete();
    cyc();

    idle(); enq_valid = 2'b11; enq_data = {32'hF1, 32'hF0};
    push(32'hF0, 4'd10);
    push(32'hF1, 4'd11);
    @(negedge clk);
    chk("fl_empty", 64'(empty), 64'd1);
    chk("fl_count", 64'(count), 64'd0);
    chk("fl_deq_valid", 64'(deq_valid), 64'h0);
    chk("fl_head", 64'(deq_addr), 64'hBA);
    chk("fl_tail", 64'(enq_addr), 64'hBA);
    chk("fl_enq_ready", 64'(enq_ready), 64'h3);
    cyc();
    idle(); deq_ready = 2'b11;
    @(negedge clk);
    chk("refill_count", 64'(count), 64'd2);
    chk("refill_deq_valid", 64'(deq_valid), 64'h3);
    cyc();
    idle();
    @(negedge clk);
    chk("final_empty", 64'(empty), 64'd1);
    chk("final_queue", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
